// File: rtl/core_inst_seq.sv
// Instruction sequencer for one corelet tile: weight load, kernel load, activation load,
// execute and OFIFO drain to PMEM, emitting a registered 34-bit inst word each cycle.
module core_inst_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int L0_DEPTH = 64,
    parameter int AW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] n_act,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] act_base,
    input  logic [AW-1:0] out_base,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WLD, S_KLD, S_KWAIT, S_ALD, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] ROW_W     = (AW+1)'(row);
    localparam logic [AW:0] COL_W     = (AW+1)'(col);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(L0_DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   j_q, j_d;
    logic          l0wr_pend_q, l0wr_pend_d;
    logic          pm_pend_q, pm_pend_d;
    logic [AW-1:0] n_act_q, n_act_d;
    logic [AW-1:0] w_base_q, w_base_d;
    logic [AW-1:0] act_base_q, act_base_d;
    logic [AW-1:0] out_base_q, out_base_d;
    logic [33:0]   inst_q, inst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [AW:0]   n_w, n_in, cnt_inc, j_inc;
    logic          legal;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        j_d         = j_q;
        l0wr_pend_d = 1'b0;
        pm_pend_d   = 1'b0;
        n_act_d     = n_act_q;
        w_base_d    = w_base_q;
        act_base_d  = act_base_q;
        out_base_d  = out_base_q;
        inst_d      = IDLE_WORD;
        err_d       = err_q;
        n_w         = {1'b0, n_act_q};
        n_in        = {1'b0, n_act};
        cnt_inc     = cnt_q + ONE;
        j_inc       = j_q + ONE;
        legal       = (n_in != '0) && (n_in <= DEPTH_W);

        // SRAM read data lands one cycle later, so the L0 write trails each XMEM read
        inst_d[2] = l0wr_pend_q;
        if (pm_pend_q) begin
            inst_d[32]    = 1'b0;
            inst_d[31]    = 1'b0;
            inst_d[30:20] = out_base_q + j_q[AW-1:0];
            j_d           = j_inc;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                rd_cnt_d = '0;
                j_d      = '0;
                if (start) begin
                    if (legal) begin
                        n_act_d    = n_act;
                        w_base_d   = w_base;
                        act_base_d = act_base;
                        out_base_d = out_base;
                        state_d    = S_WLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WLD: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = w_base_q + cnt_q[AW-1:0];
                l0wr_pend_d  = 1'b1;
                cnt_d        = (cnt_inc == ROW_W) ? '0 : cnt_inc;
                if (cnt_inc == ROW_W) state_d = S_KLD;
            end
            S_KLD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
                cnt_d     = (cnt_inc == ROW_W) ? '0 : cnt_inc;
                if (cnt_inc == ROW_W) state_d = S_KWAIT;
            end
            S_KWAIT: begin
                cnt_d = (cnt_inc == COL_W) ? '0 : cnt_inc;
                if (cnt_inc == COL_W) state_d = S_ALD;
            end
            S_ALD: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = act_base_q + cnt_q[AW-1:0];
                l0wr_pend_d  = 1'b1;
                cnt_d        = (cnt_inc == n_w) ? '0 : cnt_inc;
                if (cnt_inc == n_w) state_d = S_EXEC;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
                cnt_d     = (cnt_inc == n_w) ? '0 : cnt_inc;
                if (cnt_inc == n_w) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // PMEM write of row j is issued alongside the OFIFO read of row j+1
                if (ofifo_valid && (rd_cnt_q < n_w)) begin
                    inst_d[6] = 1'b1;
                    pm_pend_d = 1'b1;
                    rd_cnt_d  = rd_cnt_q + ONE;
                end
                if (pm_pend_q && (j_inc == n_w)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_q != S_IDLE) && (state_q != S_DONE);
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            j_q         <= '0;
            l0wr_pend_q <= 1'b0;
            pm_pend_q   <= 1'b0;
            n_act_q     <= '0;
            w_base_q    <= '0;
            act_base_q  <= '0;
            out_base_q  <= '0;
            inst_q      <= IDLE_WORD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            j_q         <= j_d;
            l0wr_pend_q <= l0wr_pend_d;
            pm_pend_q   <= pm_pend_d;
            n_act_q     <= n_act_d;
            w_base_q    <= w_base_d;
            act_base_q  <= act_base_d;
            out_base_q  <= out_base_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: directed tiles with randomized bases, counts and OFIFO
// availability, compared cycle by cycle with a phase-timeline model of the tile.
module tb_core_inst_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int MAXC = 1024;
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] n_act = '0;
    logic [10:0] w_base = '0;
    logic [10:0] act_base = '0;
    logic [10:0] out_base = '0;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;

    bit          vld[MAXC];
    bit          e_xr[MAXC];
    logic [10:0] e_xa[MAXC];
    bit          e_l0wr[MAXC];
    bit          e_l0rd[MAXC];
    bit          e_ex[MAXC];
    bit          e_kl[MAXC];
    bit          e_ord[MAXC];
    bit          e_pw[MAXC];
    logic [10:0] e_pa[MAXC];

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start(start), .n_act(n_act),
        .w_base(w_base), .act_base(act_base), .out_base(out_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] mk(input bit pw, input logic [10:0] pa, input bit xr,
                                       input logic [10:0] xa, input bit ord, input bit l0rd,
                                       input bit l0wr, input bit ex, input bit kl);
        return {1'b0, ~pw, ~pw, (pw ? pa : 11'd0), ~xr, 1'b1, (xr ? xa : 11'd0),
                ord, 2'b00, l0rd, l0wr, ex, kl};
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Timeline in cycles after the start-accepting edge; inst shows phase work one cycle late.
    task automatic run_tile(input int n, input logic [10:0] wb, input logic [10:0] ab,
                            input logic [10:0] ob, input int vmode, input int bs_c,
                            input int ab_c);
        int rc;
        int last;
        int len;
        int a0;
        int d0;
        for (int c = 0; c < MAXC; c++) begin
            e_xr[c] = 0; e_xa[c] = '0; e_l0wr[c] = 0; e_l0rd[c] = 0; e_ex[c] = 0;
            e_kl[c] = 0; e_ord[c] = 0; e_pw[c] = 0; e_pa[c] = '0;
            case (vmode)
                0:       vld[c] = 1'b1;
                1:       vld[c] = (c % 3 == 0);
                default: vld[c] = (c % 4 == 0) ? 1'b1 : bit'($urandom_range(0, 1));
            endcase
        end
        for (int k = 0; k < ROW; k++) begin
            e_xr[1+k] = 1; e_xa[1+k] = 11'(int'(wb) + k); e_l0wr[2+k] = 1;
            e_l0rd[1+ROW+k] = 1; e_kl[1+ROW+k] = 1;
        end
        a0 = 2*ROW + COL;
        for (int i = 0; i < n; i++) begin
            e_xr[a0+1+i] = 1; e_xa[a0+1+i] = 11'(int'(ab) + i); e_l0wr[a0+2+i] = 1;
            e_l0rd[a0+1+n+i] = 1; e_ex[a0+1+n+i] = 1;
        end
        d0 = a0 + 2*n;
        rc = 0;
        last = d0;
        for (int c = d0; (c < MAXC - 4) && (rc < n); c++) begin
            if (vld[c]) begin
                e_ord[c+1] = 1; e_pw[c+2] = 1; e_pa[c+2] = 11'(int'(ob) + rc);
                rc++; last = c + 2;
            end
        end
        len = last + 3;

        n_act = 11'(n); w_base = wb; act_base = ab; out_base = ob;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < len; c++) begin
            ofifo_valid = vld[c];
            start = (c == bs_c);
            if (c == bs_c) begin
                n_act = '0; w_base = 11'($urandom); act_base = 11'($urandom);
                out_base = 11'($urandom);
            end
            if (c == ab_c) begin
                reset = 1'b0;
                #1;
                chk("abort inst", inst, IDLE_WORD);
                chk("abort busy", 34'(busy), 34'd0);
                chk("abort done", 34'(done), 34'd0);
                chk("abort err", 34'(err), 34'd0);
                err_exp = 1'b0;
                start = 1'b0; ofifo_valid = 1'b0;
                @(posedge clk); #1 reset = 1'b1;
                ofifo_valid = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("post-abort inst", inst, IDLE_WORD);
                    chk("post-abort busy", 34'(busy), 34'd0);
                end
                ofifo_valid = 1'b0;
                return;
            end
            @(negedge clk);
            chk($sformatf("inst c=%0d", c), inst,
                mk(e_pw[c], e_pa[c], e_xr[c], e_xa[c], e_ord[c], e_l0rd[c], e_l0wr[c],
                   e_ex[c], e_kl[c]));
            chk($sformatf("busy c=%0d", c), 34'(busy), 34'((c >= 1) && (c <= last)));
            chk($sformatf("done c=%0d", c), 34'(done), 34'(c == last + 1));
            chk($sformatf("err c=%0d", c), 34'(err), 34'(err_exp));
            @(posedge clk); #1;
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
    endtask

    task automatic illegal_start(input logic [10:0] n);
        @(posedge clk); #1 n_act = n; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        err_exp = 1'b1;
        @(negedge clk);
        chk("illegal err", 34'(err), 34'd1);
        chk("illegal busy", 34'(busy), 34'd0);
        chk("illegal inst", inst, IDLE_WORD);
        repeat (3) begin
            @(negedge clk);
            chk("illegal stays idle", inst, IDLE_WORD);
            chk("illegal no busy", 34'(busy), 34'd0);
        end
    endtask

    initial begin
        #5 reset = 1'b0;
        #1;
        chk("reset inst", inst, IDLE_WORD);
        chk("reset busy", 34'(busy), 34'd0);
        chk("reset done", 34'(done), 34'd0);
        chk("reset err", 34'(err), 34'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_tile(36, 11'd0, 11'd64, 11'd0, 0, -1, -1);
        run_tile($urandom_range(5, 20), 11'($urandom), 11'($urandom), 11'($urandom), 1, -1, -1);
        run_tile(64, 11'($urandom), 11'($urandom), 11'($urandom), 2, -1, -1);
        run_tile(4, 11'd100, 11'd2046, 11'd500, 2, 2*ROW + COL + 4 + 1, -1);
        run_tile($urandom_range(1, 10), 11'd2044, 11'($urandom), 11'd2040, 2, -1, -1);

        illegal_start(11'd0);
        illegal_start(11'd65);
        run_tile($urandom_range(2, 12), 11'($urandom), 11'($urandom), 11'($urandom), 2, -1, -1);

        run_tile(30, 11'd10, 11'd200, 11'd300, 0, -1, 2*ROW + COL + 60 + 11);
        run_tile(30, 11'd10, 11'd200, 11'd300, 2, -1, -1);
        run_tile(1, 11'($urandom), 11'($urandom), 11'($urandom), 2, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
